// File: rtl/mac_pkg.sv
// Shared types for the integer MAC initiator path: operand/accumulator widths,
// feeder FSM states and the buffered operand-pair record.
package mac_pkg;

  typedef logic signed [15:0] operand_t;
  typedef logic signed [31:0] acc_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    WAIT,
    NEXT,
    RESULT,
    ERROR
  } feeder_state_e;

  typedef struct packed {
    operand_t a;
    operand_t b;
    logic     last;
  } pair_t;

endpackage

// File: rtl/mac_int_feeder_if.sv
// Bundle of the feeder's operand-in, MAC-side and result-out signals.
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; in_valid/in_a/in_b/in_last must hold until accepted, and res_valid holds
// res_data stable until res_ready. mac_valid and mac_done are single-cycle pulses.
interface mac_int_feeder_if
  import mac_pkg::*;
();

  logic     in_valid;
  logic     in_ready;
  operand_t in_a;
  operand_t in_b;
  logic     in_last;

  logic     mac_clr;
  logic     mac_valid;
  operand_t mac_a;
  operand_t mac_b;
  acc_t     mac_y;
  logic     mac_done;

  logic     res_valid;
  acc_t     res_data;
  logic     res_ready;

  logic     busy;
  logic     timeout_err;

  modport master (
    input  in_valid, in_a, in_b, in_last, mac_y, mac_done, res_ready,
    output in_ready, mac_clr, mac_valid, mac_a, mac_b, res_valid, res_data,
           busy, timeout_err
  );

  modport slave (
    output in_valid, in_a, in_b, in_last, mac_y, mac_done, res_ready,
    input  in_ready, mac_clr, mac_valid, mac_a, mac_b, res_valid, res_data,
           busy, timeout_err
  );

endinterface

// File: rtl/mac_pair_fifo.sv
// Synchronous FIFO of operand pairs with full/empty/count; head is visible on
// rd_data whenever the FIFO is non-empty.
module mac_pair_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  pair_t                    wr_data,
  output pair_t                    rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  pair_t          mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wr_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_int_feeder.sv
// Initiator for mac_int_fsm: buffers operand pairs, issues them one per done,
// clears the accumulator at each vector start and returns one result per vector.
module mac_int_feeder
  import mac_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  mac_int_feeder_if.master       bus,
  output feeder_state_e          dbg_state,
  output logic [$clog2(DEPTH):0] dbg_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  feeder_state_e state;
  logic [TW-1:0] timer;
  logic          last_q;
  operand_t      mac_a_q;
  operand_t      mac_b_q;
  acc_t          res_q;

  pair_t         wr_pair;
  pair_t         head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign wr_pair = '{a: bus.in_a, b: bus.in_b, last: bus.in_last};
  assign push    = bus.in_valid && bus.in_ready;
  assign pop     = (state == ISSUE);

  mac_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_pair),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (dbg_count)
  );

  // Outputs decode from state and registers only; mac_done/res_ready never
  // reach an output combinationally.
  assign bus.in_ready    = !fifo_full && (state != ERROR);
  assign bus.mac_clr     = (state == CLEAR);
  assign bus.mac_valid   = (state == ISSUE);
  assign bus.mac_a       = mac_a_q;
  assign bus.mac_b       = mac_b_q;
  assign bus.res_valid   = (state == RESULT);
  assign bus.res_data    = res_q;
  assign bus.busy        = (state != IDLE);
  assign bus.timeout_err = (state == ERROR);
  assign dbg_state       = state;

  // Operands are loaded on the way into ISSUE so they are already valid in the
  // issue cycle and then held until the next issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      last_q  <= 1'b0;
      mac_a_q <= '0;
      mac_b_q <= '0;
      res_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) state <= CLEAR;
        end
        CLEAR: begin
          mac_a_q <= head.a;
          mac_b_q <= head.b;
          state   <= ISSUE;
        end
        ISSUE: begin
          last_q <= head.last;
          timer  <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (bus.mac_done) begin
            if (last_q) begin
              res_q <= bus.mac_y;
              state <= RESULT;
            end else begin
              state <= NEXT;
            end
          end else if (timer == TW'(TIMEOUT)) begin
            state <= ERROR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        NEXT: begin
          if (!fifo_empty) begin
            mac_a_q <= head.a;
            mac_b_q <= head.b;
            state   <= ISSUE;
          end
        end
        RESULT: begin
          if (bus.res_ready) state <= IDLE;
        end
        ERROR: begin
          state <= ERROR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
